// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
// Module   : collision_detector
// Purpose  : 3-stage separating-axis overlap test for two oriented boxes.
//            Define COLLISION_PREDICT_EN to test positions advanced one step.
// Revision : 1.0 - initial release
// ============================================================================
module collision_detector (
    input  logic               clk,
    input  logic               reset,
    input  logic        [7:0]  widthA,
    input  logic        [7:0]  heightA,
    input  logic signed [31:0] posA_x,
    input  logic signed [31:0] posA_y,
    input  logic signed [23:0] velA_x,
    input  logic signed [23:0] velA_y,
    input  logic signed [15:0] uA_x,
    input  logic signed [15:0] uA_y,
    input  logic signed [15:0] vA_x,
    input  logic signed [15:0] vA_y,
    input  logic        [7:0]  widthB,
    input  logic        [7:0]  heightB,
    input  logic signed [31:0] posB_x,
    input  logic signed [31:0] posB_y,
    input  logic signed [23:0] velB_x,
    input  logic signed [23:0] velB_y,
    input  logic signed [15:0] uB_x,
    input  logic signed [15:0] uB_y,
    input  logic signed [15:0] vB_x,
    input  logic signed [15:0] vB_y,
    output logic               is_collision
);

`ifdef COLLISION_PREDICT_EN
    localparam int c_DW = 35;
`else
    localparam int c_DW = 33;
`endif
    // Each width carries one guard bit so negating the most-negative value is safe.
    localparam int c_PW    = c_DW + 18;   // d.n, 39 fractional bits
    localparam int c_QW    = 34;          // axis.axis, 28 fractional bits
    localparam int c_RW    = c_QW + 10;   // sum of extent * |axis.axis|, 29 fractional bits
    localparam int c_ALIGN = 10;          // 39 - 29 fractional bits
    localparam int c_CW    = 56;

    // ------------------------------------------------------------------------
    // S1: centre difference
    // ------------------------------------------------------------------------
    logic signed [c_DW-1:0] w_d_x;
    logic signed [c_DW-1:0] w_d_y;

`ifdef COLLISION_PREDICT_EN
    logic signed [33:0] w_pa_x;
    logic signed [33:0] w_pa_y;
    logic signed [33:0] w_pb_x;
    logic signed [33:0] w_pb_y;

    // Velocity has 19 fractional bits; shift by 6 to meet the 25-bit position point.
    assign w_pa_x = 34'(posA_x) + 34'($signed({velA_x, 6'b0}));
    assign w_pa_y = 34'(posA_y) + 34'($signed({velA_y, 6'b0}));
    assign w_pb_x = 34'(posB_x) + 34'($signed({velB_x, 6'b0}));
    assign w_pb_y = 34'(posB_y) + 34'($signed({velB_y, 6'b0}));
    assign w_d_x  = c_DW'(w_pb_x) - c_DW'(w_pa_x);
    assign w_d_y  = c_DW'(w_pb_y) - c_DW'(w_pa_y);
`else
    logic w_unused_vel;

    assign w_d_x        = c_DW'(posB_x) - c_DW'(posA_x);
    assign w_d_y        = c_DW'(posB_y) - c_DW'(posA_y);
    assign w_unused_vel = ^{velA_x, velA_y, velB_x, velB_y};
`endif

    // Axis k is paired with extent k: uA/widthA, vA/heightA, uB/widthB, vB/heightB.
    logic signed [c_DW-1:0] r_d_x;
    logic signed [c_DW-1:0] r_d_y;
    logic signed [15:0]     r_ax_x [4];
    logic signed [15:0]     r_ax_y [4];
    logic        [7:0]      r_ext  [4];
    logic                   r_vld1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_x  <= '0;
            r_d_y  <= '0;
            r_vld1 <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_ax_x[k] <= '0;
                r_ax_y[k] <= '0;
                r_ext[k]  <= '0;
            end
        end else begin
            r_d_x     <= w_d_x;
            r_d_y     <= w_d_y;
            r_vld1    <= 1'b1;
            r_ax_x[0] <= uA_x;
            r_ax_y[0] <= uA_y;
            r_ax_x[1] <= vA_x;
            r_ax_y[1] <= vA_y;
            r_ax_x[2] <= uB_x;
            r_ax_y[2] <= uB_y;
            r_ax_x[3] <= vB_x;
            r_ax_y[3] <= vB_y;
            r_ext[0]  <= widthA;
            r_ext[1]  <= heightA;
            r_ext[2]  <= widthB;
            r_ext[3]  <= heightB;
        end
    end

    // ------------------------------------------------------------------------
    // S2: projected distance and combined projected radius per axis
    // ------------------------------------------------------------------------
    logic        [c_PW-1:0] w_p [4];
    logic        [c_RW-1:0] w_r [4];
    logic signed [c_PW-1:0] w_dp;
    logic signed [c_QW-1:0] w_ap;
    logic        [c_QW-1:0] w_ap_abs;

    // Half-extent has one fractional bit, so extent * |a.n| is exact at 29 bits.
    always_comb begin
        w_dp     = '0;
        w_ap     = '0;
        w_ap_abs = '0;
        for (int n = 0; n < 4; n++) begin
            w_dp   = c_PW'(r_d_x) * c_PW'(r_ax_x[n]) + c_PW'(r_d_y) * c_PW'(r_ax_y[n]);
            w_p[n] = w_dp[c_PW-1] ? -w_dp : w_dp;
            w_r[n] = '0;
            for (int k = 0; k < 4; k++) begin
                w_ap     = c_QW'(r_ax_x[k]) * c_QW'(r_ax_x[n])
                         + c_QW'(r_ax_y[k]) * c_QW'(r_ax_y[n]);
                w_ap_abs = w_ap[c_QW-1] ? -w_ap : w_ap;
                w_r[n]   = w_r[n] + c_RW'(r_ext[k]) * c_RW'(w_ap_abs);
            end
        end
    end

    logic [c_PW-1:0] r_p [4];
    logic [c_RW-1:0] r_r [4];
    logic            r_vld2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld2 <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                r_p[n] <= '0;
                r_r[n] <= '0;
            end
        end else begin
            r_vld2 <= r_vld1;
            for (int n = 0; n < 4; n++) begin
                r_p[n] <= w_p[n];
                r_r[n] <= w_r[n];
            end
        end
    end

    // ------------------------------------------------------------------------
    // S3: separation test; touching is not a separation
    // ------------------------------------------------------------------------
    logic w_any_sep;
    logic r_is_coll;

    always_comb begin
        w_any_sep = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (c_CW'(r_p[n]) > c_CW'({r_r[n], {c_ALIGN{1'b0}}}))
                w_any_sep = 1'b1;
        end
    end

    // The valid chain masks the cleared pipeline contents right after reset.
    always_ff @(posedge clk) begin
        if (reset)
            r_is_coll <= 1'b0;
        else
            r_is_coll <= r_vld2 & ~w_any_sep;
    end

    assign is_collision = r_is_coll;

endmodule
`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_detector
// Purpose  : Directed plus randomized checks of collision_detector against an
//            integer separating-axis model with a 3-cycle latency queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_collision_detector;

    typedef struct packed {
        logic        [7:0]  w;
        logic        [7:0]  h;
        logic signed [31:0] px;
        logic signed [31:0] py;
        logic signed [23:0] velx;
        logic signed [23:0] vely;
        logic signed [15:0] ux;
        logic signed [15:0] uy;
        logic signed [15:0] vx;
        logic signed [15:0] vy;
    } box_t;

`ifdef COLLISION_PREDICT_EN
    localparam logic c_PRED = 1'b1;
`else
    localparam logic c_PRED = 1'b0;
`endif

    logic     clk   = 1'b0;
    logic     reset = 1'b1;
    box_t     a     = '0;
    box_t     b     = '0;
    logic     is_collision;
    int       n_tests = 0;
    int       n_fail  = 0;
    bit [2:0] m_vld   = '0;
    bit [2:0] m_val   = '0;

    always #5 clk = ~clk;

    collision_detector dut (
        .clk          (clk),
        .reset        (reset),
        .widthA       (a.w),
        .heightA      (a.h),
        .posA_x       (a.px),
        .posA_y       (a.py),
        .velA_x       (a.velx),
        .velA_y       (a.vely),
        .uA_x         (a.ux),
        .uA_y         (a.uy),
        .vA_x         (a.vx),
        .vA_y         (a.vy),
        .widthB       (b.w),
        .heightB      (b.h),
        .posB_x       (b.px),
        .posB_y       (b.py),
        .velB_x       (b.velx),
        .velB_y       (b.vely),
        .uB_x         (b.ux),
        .uB_y         (b.uy),
        .vB_x         (b.vx),
        .vB_y         (b.vy),
        .is_collision (is_collision)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: is_collision=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // Everything scaled to 2^-39: d (2^-25) * n (2^-14); extent/2 * |a.n| (2^-29) * 2^10.
    function automatic logic model_hit(input box_t ba, input box_t bb);
        longint dx, dy, p, r;
        longint ax [4];
        longint ay [4];
        longint ext [4];
        dx = longint'($signed(bb.px)) - longint'($signed(ba.px));
        dy = longint'($signed(bb.py)) - longint'($signed(ba.py));
`ifdef COLLISION_PREDICT_EN
        dx += (longint'($signed(bb.velx)) - longint'($signed(ba.velx))) * 64;
        dy += (longint'($signed(bb.vely)) - longint'($signed(ba.vely))) * 64;
`endif
        ax[0] = longint'($signed(ba.ux)); ay[0] = longint'($signed(ba.uy)); ext[0] = longint'(ba.w);
        ax[1] = longint'($signed(ba.vx)); ay[1] = longint'($signed(ba.vy)); ext[1] = longint'(ba.h);
        ax[2] = longint'($signed(bb.ux)); ay[2] = longint'($signed(bb.uy)); ext[2] = longint'(bb.w);
        ax[3] = longint'($signed(bb.vx)); ay[3] = longint'($signed(bb.vy)); ext[3] = longint'(bb.h);
        for (int n = 0; n < 4; n++) begin
            p = labs(dx * ax[n] + dy * ay[n]);
            r = 0;
            for (int k = 0; k < 4; k++)
                r += ext[k] * labs(ax[k] * ax[n] + ay[k] * ay[n]);
            if (p > r * 1024)
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic signed [31:0] pos_q(input real r);
        return 32'($rtoi(r * 33554432.0));
    endfunction

    function automatic logic signed [15:0] q14(input real r);
        return 16'($rtoi(r * 16384.0 + ((r >= 0.0) ? 0.5 : -0.5)));
    endfunction

    function automatic box_t unit_box(input real x, input real y);
        box_t bx;
        bx    = '0;
        bx.w  = 8'd10;
        bx.h  = 8'd10;
        bx.px = pos_q(x);
        bx.py = pos_q(y);
        bx.ux = 16'sd16384;
        bx.vy = 16'sd16384;
        return bx;
    endfunction

    function automatic box_t rand_box();
        box_t bx;
        real  ang;
        int   ip;
        bx   = '0;
        bx.w = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
        bx.h = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
        if ($urandom_range(0, 19) == 0) begin
            bx.px = 32'($urandom);
            bx.py = 32'($urandom);
        end else begin
            ip    = int'($urandom_range(0, 60)) - 30;
            bx.px = 32'(ip * 33554432 + int'($urandom_range(0, 33554431)));
            ip    = int'($urandom_range(0, 60)) - 30;
            bx.py = 32'(ip * 33554432 + int'($urandom_range(0, 33554431)));
        end
        bx.velx = ($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'(int'($urandom_range(0, 4194304)) - 2097152);
        bx.vely = 24'(int'($urandom_range(0, 4194304)) - 2097152);
        if ($urandom_range(0, 3) == 0) begin
            bx.ux = 16'($urandom);
            bx.uy = 16'($urandom);
            bx.vx = 16'($urandom);
            bx.vy = 16'($urandom);
        end else begin
            ang   = real'($urandom_range(0, 359)) * 3.14159265358979 / 180.0;
            bx.ux = q14($cos(ang));
            bx.uy = q14($sin(ang));
            bx.vx = -bx.uy;
            bx.vy = bx.ux;
        end
        return bx;
    endfunction

    // One clock: inputs as currently driven, model queue advanced, output compared.
    task automatic step(input string tag, input logic rst_in);
        logic e;
        reset = rst_in;
        e     = model_hit(a, b);
        @(posedge clk);
        if (rst_in) begin
            m_vld = '0;
            m_val = '0;
        end else begin
            m_vld = {m_vld[1:0], 1'b1};
            m_val = {m_val[1:0], e};
        end
        #1;
        check_eq(tag, is_collision, m_vld[2] & m_val[2]);
    endtask

    task automatic hold(input string tag, input logic want);
        repeat (3) step(tag, 1'b0);
        check_eq({tag, "_const"}, is_collision, want);
    endtask

    initial begin
        step("reset", 1'b1);
        step("reset", 1'b1);

        a = unit_box(7.0, 7.0);
        b = unit_box(20.0, 7.0);
        hold("sep_aligned", 1'b0);

        for (int x = 19; x >= -10; x--) begin
            b.px = pos_q(real'(x));
            step("sweep", 1'b0);
        end
        repeat (3) step("sweep_drain", 1'b0);

        b.px = pos_q(18.0);  hold("edge_18", 1'b0);
        b.px = pos_q(17.0);  hold("touch_17", 1'b1);
        b.px = pos_q(-3.0);  hold("touch_m3", 1'b1);
        b.px = pos_q(-4.0);  hold("edge_m4", 1'b0);

        b    = unit_box(19.0, 7.0);
        b.ux = q14(0.70709);
        b.uy = q14(0.70709);
        b.vx = q14(-0.70709);
        b.vy = q14(0.70709);
        hold("rot_19", 1'b1);
        b.px = pos_q(20.0);
        hold("rot_20", 1'b0);

        a   = unit_box(-3.5, 2.25);
        b   = unit_box(-3.5, 2.25);
        b.w = 8'd0;
        b.h = 8'd0;
        hold("coincident", 1'b1);
        a     = unit_box(-40.75, -60.5);
        b.px  = a.px;
        b.py  = a.py;
        hold("coincident_neg", 1'b1);
        a.w = 8'd0;
        a.h = 8'd0;
        hold("point_point", 1'b1);

        a = unit_box(7.0, 7.0);
        b = unit_box(10.0, 7.0);
        step("mid_pre", 1'b0);
        step("mid_reset", 1'b1);
        check_eq("mid_reset_zero", is_collision, 1'b0);
        step("mid_post1", 1'b0);
        check_eq("mid_post1_zero", is_collision, 1'b0);
        step("mid_post2", 1'b0);
        check_eq("mid_post2_zero", is_collision, 1'b0);
        step("mid_post3", 1'b0);
        check_eq("mid_post3_one", is_collision, 1'b1);

        a      = unit_box(7.0, 7.0);
        b      = unit_box(19.0, 7.0);
        b.velx = 24'(-2 * 524288);
        hold("predict", c_PRED);

        for (int i = 0; i < 400; i++) begin
            a = rand_box();
            b = rand_box();
            if ($urandom_range(0, 3) == 0) begin
                b.px = a.px + 32'(int'($urandom_range(0, 1048576)) - 524288);
                b.py = a.py;
            end
            step("random", 1'b0);
        end
        repeat (3) step("random_drain", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
